// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_pkg
// Brief   : Shared UART types, constants and baud helper (rx now, tx later).
// Revision: 1.0
// ============================================================================
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } rx_state_t;

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module  : sync_2ff
// Brief   : Two-flop synchroniser with configurable width and reset value.
// Revision: 1.0
// ============================================================================
module sync_2ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx
// Brief   : 8-bit LSB-first UART receiver, 1 stop bit, mid-bit sampling.
//           Define UART_RX_PARITY_EN to add a parity bit (PARITY_ODD selects sense).
// Revision: 1.0
// ============================================================================
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD_RATE   = 115200,
  parameter int PARITY_ODD  = 0
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_frame_err,
  output logic                 o_parity_err
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

  if (CLKS_PER_BIT < 4) begin : g_chk_cpb
    $error("uart_rx: CLKS_PER_BIT must be at least 4");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_chk_parity
    $error("uart_rx: PARITY_ODD must be 0 or 1");
  end

  logic                 rx_s;
  logic                 rx_prev;
  rx_state_t            state, state_next;
  logic [CNT_W-1:0]     clk_cnt, clk_cnt_next;
  logic [2:0]           bit_idx, bit_idx_next;
  logic [DATA_BITS-1:0] shreg, shreg_next;
  logic [DATA_BITS-1:0] data_next;
  logic                 valid_next, frame_err_next;

  sync_2ff #(
    .WIDTH    (1),
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk(i_clk),
    .rst(i_rst),
    .d  (i_rx),
    .q  (rx_s)
  );

`ifdef UART_RX_PARITY_EN
  logic parity_ok, parity_ok_next, parity_err_next;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= ST_IDLE;
      rx_prev     <= 1'b0;
      clk_cnt     <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      state       <= state_next;
      rx_prev     <= rx_s;
      clk_cnt     <= clk_cnt_next;
      bit_idx     <= bit_idx_next;
      shreg       <= shreg_next;
      o_data      <= data_next;
      o_valid     <= valid_next;
      o_frame_err <= frame_err_next;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      parity_ok    <= 1'b0;
      o_parity_err <= 1'b0;
    end else begin
      parity_ok    <= parity_ok_next;
      o_parity_err <= parity_err_next;
    end
  end
`else
  assign o_parity_err = 1'b0;
`endif

  always_comb begin
    state_next     = state;
    clk_cnt_next   = clk_cnt;
    bit_idx_next   = bit_idx;
    shreg_next     = shreg;
    data_next      = o_data;
    valid_next     = 1'b0;
    frame_err_next = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_ok_next  = parity_ok;
    parity_err_next = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (rx_prev && !rx_s) begin
          state_next   = ST_START;
          clk_cnt_next = '0;
        end
      end
      ST_START: begin
        // Half a bit in: a line that has gone high again was only a glitch.
        if (clk_cnt == CNT_HALF) begin
          clk_cnt_next = '0;
          bit_idx_next = '0;
          state_next   = rx_s ? ST_IDLE : ST_DATA;
        end else begin
          clk_cnt_next = clk_cnt + 1'b1;
        end
      end
      ST_DATA: begin
        if (clk_cnt == CNT_FULL) begin
          clk_cnt_next        = '0;
          shreg_next[bit_idx] = rx_s;
          bit_idx_next        = bit_idx + 1'b1;
          if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_next = ST_PARITY;
`else
            state_next = ST_STOP;
`endif
          end
        end else begin
          clk_cnt_next = clk_cnt + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (clk_cnt == CNT_FULL) begin
          clk_cnt_next   = '0;
          parity_ok_next = ((^shreg) ^ rx_s) == (PARITY_ODD != 0);
          state_next     = ST_STOP;
        end else begin
          clk_cnt_next = clk_cnt + 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (clk_cnt == CNT_FULL) begin
          clk_cnt_next = '0;
          if (!rx_s) begin
            frame_err_next = 1'b1;
            state_next     = ST_BREAK;
          end
`ifdef UART_RX_PARITY_EN
          else if (!parity_ok) begin
            parity_err_next = 1'b1;
            state_next      = ST_IDLE;
          end
`endif
          else begin
            valid_next = 1'b1;
            data_next  = shreg;
            state_next = ST_IDLE;
          end
        end else begin
          clk_cnt_next = clk_cnt + 1'b1;
        end
      end
      ST_BREAK: begin
        if (rx_s) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_rx
// Brief   : Randomised self-checking bench for uart_rx against an event-list model.
// Revision: 1.0
// ============================================================================
module tb_uart_rx;

  localparam int CLK_HZ  = 50_000_000;
  localparam int BAUD    = 115200;
  localparam int CPB     = CLK_HZ / BAUD;
  localparam int PAR_ODD = 0;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  // Pulse lands one clock after the mid-sample of the stop bit.
  localparam int LAT_NOM = CPB / 2 + (FRAME_BITS - 1) * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data;
  logic       valid, ferr, perr;

  always #10 clk = ~clk;

  uart_rx #(
    .CLK_FREQ_HZ(CLK_HZ),
    .BAUD_RATE  (BAUD),
    .PARITY_ODD (PAR_ODD)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_rx        (rx),
    .o_data      (data),
    .o_valid     (valid),
    .o_frame_err (ferr),
    .o_parity_err(perr)
  );

  typedef struct {
    int         kind;   // 0 valid, 1 frame error, 2 parity error
    logic [7:0] d;
    int         cyc;
  } ev_t;

  ev_t        got_q[$];
  ev_t        exp_q[$];
  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;
  int         onehot_viol = 0;
  int         last_start  = 0;
  logic [7:0] last_data   = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid || ferr || perr) begin
      if (int'(valid) + int'(ferr) + int'(perr) > 1) onehot_viol = onehot_viol + 1;
      if (valid)     got_q.push_back('{0, data, cyc});
      else if (ferr) got_q.push_back('{1, data, cyc});
      else           got_q.push_back('{2, data, cyc});
    end
  end

  function automatic logic good_par(input logic [7:0] d);
    return (($countones(d) % 2) != PAR_ODD);
  endfunction

  // Reference: what the receiver must report for a complete frame.
  task automatic model_frame(input logic [7:0] d, input logic stop_v, input logic p);
    if (!stop_v) begin
      exp_q.push_back('{1, last_data, 0});
    end
`ifdef UART_RX_PARITY_EN
    else if ((($countones(d) + int'(p)) % 2) != PAR_ODD) begin
      exp_q.push_back('{2, last_data, 0});
    end
`endif
    else begin
      exp_q.push_back('{0, d, 0});
      last_data = d;
    end
  endtask

  // Called on a negedge; drives one full frame and leaves the line at stop_v.
  task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic p);
    last_start = cyc;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rx = p;
    repeat (CPB) @(negedge clk);
`endif
    rx = stop_v;
    repeat (CPB) @(negedge clk);
    model_frame(d, stop_v, p);
  endtask

  task automatic clear_logs();
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx  = 1'b1;
    repeat (4) @(negedge clk);
    total++;
    if ({data, valid, ferr, perr} !== 11'h000) begin
      bad++;
      $display("FAIL reset_outputs: got data=%h v=%b fe=%b pe=%b, want all 0", data, valid, ferr, perr);
    end
    rst = 1'b0;
    last_data = 8'h00;
    repeat (2 * CPB) @(negedge clk);
    total++;
    if (got_q.size() != 0) begin
      bad++;
      $display("FAIL reset_idle: got %0d events after reset, want 0", got_q.size());
    end
  endtask

  task automatic test_single();
    clear_logs();
    send_frame(8'hA5, 1'b1, good_par(8'hA5));
    repeat (4) @(negedge clk);
    total++;
    if (got_q.size() != 1 || got_q[0].kind != 0 || got_q[0].d !== 8'hA5) begin
      bad++;
      $display("FAIL single_a5: got %0d events (first kind=%0d data=%h), want one valid 0xa5",
               got_q.size(), got_q.size() ? got_q[0].kind : -1, got_q.size() ? got_q[0].d : 8'hxx);
    end else begin
      total++;
      if (got_q[0].cyc - last_start < LAT_NOM - 4 || got_q[0].cyc - last_start > LAT_NOM + 8) begin
        bad++;
        $display("FAIL single_latency: got %0d clks, want about %0d", got_q[0].cyc - last_start, LAT_NOM);
      end
    end
    total++;
    if (data !== 8'hA5) begin
      bad++;
      $display("FAIL single_hold: got data=%h, want a5", data);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b[3];
    b = '{8'h00, 8'hFF, 8'h55};
    clear_logs();
    for (int i = 0; i < 3; i++) send_frame(b[i], 1'b1, good_par(b[i]));
    repeat (4) @(negedge clk);
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL b2b_count: got %0d events, want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i].kind != exp_q[i].kind || got_q[i].d !== exp_q[i].d) begin
        bad++;
        $display("FAIL b2b_event%0d: got kind=%0d data=%h, want kind=%0d data=%h",
                 i, got_q[i].kind, got_q[i].d, exp_q[i].kind, exp_q[i].d);
      end
    end
  endtask

  task automatic test_glitch();
    clear_logs();
    rx = 1'b0;
    repeat (100) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    total++;
    if (got_q.size() != 0) begin
      bad++;
      $display("FAIL glitch_nopulse: got %0d events, want 0", got_q.size());
    end
    send_frame(8'h3C, 1'b1, good_par(8'h3C));
    repeat (4) @(negedge clk);
    total++;
    if (got_q.size() != 1 || got_q[0].kind != 0 || got_q[0].d !== 8'h3C) begin
      bad++;
      $display("FAIL glitch_then_3c: got %0d events, want one valid 0x3c", got_q.size());
    end
  endtask

  task automatic test_frame_err();
    clear_logs();
    send_frame(8'h81, 1'b0, good_par(8'h81));
    rx = 1'b0;
    repeat (20 * CPB) @(negedge clk);
    rx = 1'b1;
    repeat (CPB) @(negedge clk);
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL ferr_count: got %0d events, want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i].kind != exp_q[i].kind || got_q[i].d !== exp_q[i].d) begin
        bad++;
        $display("FAIL ferr_event%0d: got kind=%0d data=%h, want kind=%0d data=%h",
                 i, got_q[i].kind, got_q[i].d, exp_q[i].kind, exp_q[i].d);
      end
    end
    total++;
    if (data !== last_data) begin
      bad++;
      $display("FAIL ferr_hold: got data=%h, want %h", data, last_data);
    end
    clear_logs();
    send_frame(8'h42, 1'b1, good_par(8'h42));
    repeat (4) @(negedge clk);
    total++;
    if (got_q.size() != 1 || got_q[0].kind != 0 || got_q[0].d !== 8'h42) begin
      bad++;
      $display("FAIL ferr_recover_42: got %0d events, want one valid 0x42", got_q.size());
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d;
    d = 8'h7E;
    clear_logs();
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = d[i];
      repeat (CPB) @(negedge clk);
    end
    rx = d[4];
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if ({data, valid, ferr, perr} !== 11'h000) begin
      bad++;
      $display("FAIL midrst_outputs: got data=%h v=%b fe=%b pe=%b, want all 0", data, valid, ferr, perr);
    end
    @(negedge clk);
    rst = 1'b0;
    rx  = 1'b1;
    last_data = 8'h00;
    repeat (2 * CPB) @(negedge clk);
    total++;
    if (got_q.size() != 0) begin
      bad++;
      $display("FAIL midrst_aborted: got %0d events, want 0", got_q.size());
    end
    send_frame(d, 1'b1, good_par(d));
    repeat (4) @(negedge clk);
    total++;
    if (got_q.size() != 1 || got_q[0].kind != 0 || got_q[0].d !== 8'h7E) begin
      bad++;
      $display("FAIL midrst_resend: got %0d events, want one valid 0x7e", got_q.size());
    end
  endtask

  task automatic test_random();
    logic [7:0] d;
    clear_logs();
    for (int i = 0; i < 3; i++) begin
      d = 8'($urandom);
      send_frame(d, 1'b1, good_par(d));
      repeat ($urandom_range(0, 40)) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL rand_count: got %0d events, want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i].kind != exp_q[i].kind || got_q[i].d !== exp_q[i].d) begin
        bad++;
        $display("FAIL rand_event%0d: got kind=%0d data=%h, want kind=%0d data=%h",
                 i, got_q[i].kind, got_q[i].d, exp_q[i].kind, exp_q[i].d);
      end
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    clear_logs();
    send_frame(8'h01, 1'b1, 1'b0);
    send_frame(8'h01, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL parity_count: got %0d events, want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i].kind != exp_q[i].kind || got_q[i].d !== exp_q[i].d) begin
        bad++;
        $display("FAIL parity_event%0d: got kind=%0d data=%h, want kind=%0d data=%h",
                 i, got_q[i].kind, got_q[i].d, exp_q[i].kind, exp_q[i].d);
      end
    end
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_midframe();
    test_random();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    total++;
    if (onehot_viol != 0) begin
      bad++;
      $display("FAIL pulse_exclusive: got %0d cycles with several pulses, want 0", onehot_viol);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
